// File: rtl/std_sram_singleport_arb2.sv
// Two-port arbiter in front of a single-port SRAM, with optional
// zero-fill of the whole array after reset.
//
// Ports:
//   clk, reset        : single clock, asynchronous active-high reset
//   pN_req_valid/ready: request handshake per port (N = 0, 1)
//   pN_req_we/addr/wdata : request payload, held stable until ready
//   pN_rsp_valid/rdata: read response, one cycle after the read grant
//   sram_en/we/addr/din : SRAM access, driven in the grant cycle
//   sram_dout         : SRAM read data, one cycle after a read access
//   init_done         : high once the array is usable (state RUN)
module std_sram_singleport_arb2 #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  init_done
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;
  localparam state_e RST_STATE =
    (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_done_q;
  // last_q: 1 = port 1 was granted most recently
  logic                  last_q, last_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  rsp_tag_q, rsp_tag_d;

  logic run;
  logic gnt0, gnt1;

  // Gating with reset keeps every strobe low while reset is held,
  // even though the state register already sits in INIT.
  assign run = (state_q == ST_RUN) && !reset;

  // Ready depends only on the valids and the pointer, never on
  // the payload of the same port.
  assign gnt0 = run & p0_req_valid & (~p1_req_valid | last_q);
  assign gnt1 = run & p1_req_valid & (~p0_req_valid | ~last_q);

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;

  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (!reset && state_q == ST_INIT) begin
      sram_en   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = cnt_q;
    end else if (gnt0) begin
      sram_en   = 1'b1;
      sram_we   = p0_req_we;
      sram_addr = p0_req_addr;
      sram_din  = p0_req_wdata;
    end else if (gnt1) begin
      sram_en   = 1'b1;
      sram_we   = p1_req_we;
      sram_addr = p1_req_addr;
      sram_din  = p1_req_wdata;
    end
  end

  always_comb begin
    last_d    = last_q;
    rsp_vld_d = (gnt0 & ~p0_req_we) | (gnt1 & ~p1_req_we);
    rsp_tag_d = gnt1;
    if (gnt0 | gnt1) begin
      last_d = gnt1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= (INIT_ON_RESET == 0);
      last_q      <= 1'b1;
      rsp_vld_q   <= 1'b0;
      rsp_tag_q   <= 1'b0;
    end else begin
      last_q    <= last_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_tag_q <= rsp_tag_d;
      unique case (state_q)
        ST_INIT: begin
          // Counter stops at the top; leaving INIT ends the fill.
          if (cnt_q == CNT_MAX) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q <= RST_STATE;
        end
      endcase
    end
  end

  assign init_done    = init_done_q;
  assign p0_rsp_valid = rsp_vld_q & ~rsp_tag_q;
  assign p1_rsp_valid = rsp_vld_q & rsp_tag_q;
  assign p0_rsp_rdata = sram_dout;
  assign p1_rsp_rdata = sram_dout;

endmodule

// File: tb/tb_std_sram_singleport_arb2.sv
// Directed bench for std_sram_singleport_arb2 with a behavioural
// single-port SRAM (registered read data) attached.
module tb_std_sram_singleport_arb2;

  logic       clk;
  logic       reset;
  logic       p0_req_valid, p0_req_ready, p0_req_we;
  logic [3:0] p0_req_addr;
  logic [7:0] p0_req_wdata;
  logic       p0_rsp_valid;
  logic [7:0] p0_rsp_rdata;
  logic       p1_req_valid, p1_req_ready, p1_req_we;
  logic [3:0] p1_req_addr;
  logic [7:0] p1_req_wdata;
  logic       p1_rsp_valid;
  logic [7:0] p1_rsp_rdata;
  logic       sram_en, sram_we;
  logic [3:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;
  logic       init_done;

  int n_chk;
  int n_fail;

  logic [7:0] mem [16];

  std_sram_singleport_arb2 #(
    .ADDR_WIDTH   (4),
    .DATA_WIDTH   (8),
    .INIT_ON_RESET(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .p0_req_valid(p0_req_valid),
    .p0_req_ready(p0_req_ready),
    .p0_req_we   (p0_req_we),
    .p0_req_addr (p0_req_addr),
    .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid),
    .p1_req_ready(p1_req_ready),
    .p1_req_we   (p1_req_we),
    .p1_req_addr (p1_req_addr),
    .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_din    (sram_din),
    .sram_dout   (sram_dout),
    .init_done   (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Power-up contents are non-zero so the zero-fill is observable.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    sram_dout = 8'hEE;
  end

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else sram_dout <= mem[sram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req_valid = 0; p0_req_we = 0;
    p0_req_addr = 0;  p0_req_wdata = 0;
    p1_req_valid = 0; p1_req_we = 0;
    p1_req_addr = 0;  p1_req_wdata = 0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    logic [13:0] acc;
    reset = 1'b1;
    idle_inputs();
    #2;
    obs = {sram_en, sram_we, p0_req_ready, p1_req_ready,
           p0_rsp_valid, p1_rsp_valid, init_done};
    n_chk++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0);
    end
    tick();
    tick();
    reset = 1'b0;
    // Request held through INIT must be ignored.
    p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 4'd5;
    for (int i = 0; i < 16; i++) begin
      #1;
      acc = {sram_en, sram_we, sram_addr, sram_din};
      n_chk++;
      if (acc !== {1'b1, 1'b1, 4'(i), 8'h00}) begin
        n_fail++;
        $display("FAIL init_write[%0d] got=%h exp=%h", i, acc,
                 {1'b1, 1'b1, 4'(i), 8'h00});
      end
      n_chk++;
      if ({p0_req_ready, p1_req_ready, init_done} !== 3'b000) begin
        n_fail++;
        $display("FAIL init_ready[%0d] got=%b exp=000", i,
                 {p0_req_ready, p1_req_ready, init_done});
      end
      tick();
    end
    #1;
    n_chk++;
    if ({init_done, p0_req_ready, sram_en, sram_we, sram_addr}
        !== {1'b1, 1'b1, 1'b1, 1'b0, 4'd5}) begin
      n_fail++;
      $display("FAIL run_first_read got=%b exp=%b",
               {init_done, p0_req_ready, sram_en, sram_we, sram_addr},
               {1'b1, 1'b1, 1'b1, 1'b0, 4'd5});
    end
    tick();
    p0_req_valid = 0;
    #1;
    n_chk++;
    if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata}
        !== {2'b10, 8'h00}) begin
      n_fail++;
      $display("FAIL zero_fill_rd got=%b/%h exp=10/00",
               {p0_rsp_valid, p1_rsp_valid}, p0_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_write_read();
    p0_req_valid = 1; p0_req_we = 1;
    p0_req_addr = 4'd3; p0_req_wdata = 8'hA5;
    #1;
    n_chk++;
    if ({p0_req_ready, p1_req_ready, sram_en, sram_we, sram_addr,
         sram_din, p0_rsp_valid, p1_rsp_valid}
        !== {4'b1011, 4'd3, 8'hA5, 2'b00}) begin
      n_fail++;
      $display("FAIL wr_grant got=%b exp=%b",
               {p0_req_ready, p1_req_ready, sram_en, sram_we,
                sram_addr, sram_din, p0_rsp_valid, p1_rsp_valid},
               {4'b1011, 4'd3, 8'hA5, 2'b00});
    end
    tick();
    p0_req_we = 0;
    #1;
    n_chk++;
    if ({p0_req_ready, sram_en, sram_we, sram_addr,
         p0_rsp_valid, p1_rsp_valid}
        !== {3'b110, 4'd3, 2'b00}) begin
      n_fail++;
      $display("FAIL rd_grant got=%b exp=%b",
               {p0_req_ready, sram_en, sram_we, sram_addr,
                p0_rsp_valid, p1_rsp_valid},
               {3'b110, 4'd3, 2'b00});
    end
    tick();
    p0_req_valid = 0;
    #1;
    n_chk++;
    if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata}
        !== {2'b10, 8'hA5}) begin
      n_fail++;
      $display("FAIL raw_rsp got=%b/%h exp=10/a5",
               {p0_rsp_valid, p1_rsp_valid}, p0_rsp_rdata);
    end
    n_chk++;
    if ({sram_en, sram_we, sram_din} !== 10'b0) begin
      n_fail++;
      $display("FAIL idle_sram got=%b exp=0",
               {sram_en, sram_we, sram_din});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] a [4];
    logic [7:0] d [4];
    a = '{4'd1, 4'd2, 4'd8, 4'd9};
    d = '{8'h11, 8'h22, 8'h88, 8'h99};
    for (int k = 0; k < 4; k++) begin
      p1_req_valid = 1; p1_req_we = 1;
      p1_req_addr = a[k]; p1_req_wdata = d[k];
      #1;
      n_chk++;
      if ({p0_req_ready, p1_req_ready, sram_en, sram_we, sram_addr,
           sram_din, p0_rsp_valid, p1_rsp_valid}
          !== {4'b0111, a[k], d[k], 2'b00}) begin
        n_fail++;
        $display("FAIL b2b_wr[%0d] got=%b exp=%b", k,
                 {p0_req_ready, p1_req_ready, sram_en, sram_we,
                  sram_addr, sram_din, p0_rsp_valid, p1_rsp_valid},
                 {4'b0111, a[k], d[k], 2'b00});
      end
      tick();
    end
    p1_req_valid = 0;
    #1;
    n_chk++;
    if ({sram_en, p0_rsp_valid, p1_rsp_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_after got=%b exp=000",
               {sram_en, p0_rsp_valid, p1_rsp_valid});
    end
    tick();
  endtask

  task automatic test_arbitration();
    logic       g1;
    logic [1:0] exp_rsp;
    logic [7:0] exp_dat;
    p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 4'd1;
    p1_req_valid = 1; p1_req_we = 0; p1_req_addr = 4'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      g1 = (k % 2) == 1;
      n_chk++;
      if ({p0_req_ready, p1_req_ready, sram_we, sram_addr}
          !== {~g1, g1, 1'b0, g1 ? 4'd2 : 4'd1}) begin
        n_fail++;
        $display("FAIL arb_grant[%0d] got=%b exp=%b", k,
                 {p0_req_ready, p1_req_ready, sram_we, sram_addr},
                 {~g1, g1, 1'b0, g1 ? 4'd2 : 4'd1});
      end
      exp_rsp = (k == 0) ? 2'b00 : (g1 ? 2'b10 : 2'b01);
      n_chk++;
      if ({p0_rsp_valid, p1_rsp_valid} !== exp_rsp) begin
        n_fail++;
        $display("FAIL arb_rsp[%0d] got=%b exp=%b", k,
                 {p0_rsp_valid, p1_rsp_valid}, exp_rsp);
      end
      if (k > 0) begin
        exp_dat = g1 ? 8'h11 : 8'h22;
        n_chk++;
        if (sram_dout !== exp_dat || p0_rsp_rdata !== exp_dat ||
            p1_rsp_rdata !== exp_dat) begin
          n_fail++;
          $display("FAIL arb_data[%0d] got=%h exp=%h", k,
                   p0_rsp_rdata, exp_dat);
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    n_chk++;
    if ({p0_rsp_valid, p1_rsp_valid, p1_rsp_rdata}
        !== {2'b01, 8'h22}) begin
      n_fail++;
      $display("FAIL arb_last got=%b/%h exp=01/22",
               {p0_rsp_valid, p1_rsp_valid}, p1_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_init();
    logic [13:0] acc;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 4'd8;
    p1_req_valid = 1; p1_req_we = 0; p1_req_addr = 4'd9;
    for (int i = 0; i < 7; i++) tick();
    #1;
    n_chk++;
    if ({sram_en, sram_we, sram_addr} !== {2'b11, 4'd7}) begin
      n_fail++;
      $display("FAIL mid_init_cnt got=%b exp=%b",
               {sram_en, sram_we, sram_addr}, {2'b11, 4'd7});
    end
    #1;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({sram_en, sram_we, p0_req_ready, p1_req_ready,
         p0_rsp_valid, p1_rsp_valid, init_done} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_init_rst got=%b exp=0",
               {sram_en, sram_we, p0_req_ready, p1_req_ready,
                p0_rsp_valid, p1_rsp_valid, init_done});
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      acc = {sram_en, sram_we, sram_addr, sram_din};
      n_chk++;
      if (acc !== {2'b11, 4'(i), 8'h00} ||
          {p0_req_ready, p1_req_ready, init_done} !== 3'b000) begin
        n_fail++;
        $display("FAIL reinit[%0d] got=%h exp=%h", i, acc,
                 {2'b11, 4'(i), 8'h00});
      end
      tick();
    end
    #1;
    n_chk++;
    if ({init_done, p0_req_ready, p1_req_ready, sram_addr}
        !== {3'b110, 4'd8}) begin
      n_fail++;
      $display("FAIL first_conflict got=%b exp=%b",
               {init_done, p0_req_ready, p1_req_ready, sram_addr},
               {3'b110, 4'd8});
    end
    tick();
    p0_req_valid = 0;
    #1;
    n_chk++;
    if ({p1_req_ready, sram_addr, p0_rsp_valid, p1_rsp_valid,
         p0_rsp_rdata} !== {1'b1, 4'd9, 2'b10, 8'h00}) begin
      n_fail++;
      $display("FAIL refill_rd got=%b/%h exp=1_1001_10/00",
               {p1_req_ready, sram_addr, p0_rsp_valid, p1_rsp_valid},
               p0_rsp_rdata);
    end
    tick();
    p1_req_valid = 0;
    #1;
    n_chk++;
    if ({p0_rsp_valid, p1_rsp_valid, p1_rsp_rdata}
        !== {2'b01, 8'h00}) begin
      n_fail++;
      $display("FAIL refill_rd1 got=%b/%h exp=01/00",
               {p0_rsp_valid, p1_rsp_valid}, p1_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_rsp_abort();
    p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 4'd8;
    #1;
    n_chk++;
    if (p0_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_grant got=%b exp=1", p0_req_ready);
    end
    tick();
    p0_req_valid = 0;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_rst got=%b exp=00",
               {p0_rsp_valid, p1_rsp_valid});
    end
    tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if ({p0_rsp_valid, p1_rsp_valid, sram_we, sram_addr}
        !== {3'b001, 4'd0}) begin
      n_fail++;
      $display("FAIL abort_after got=%b exp=0010000",
               {p0_rsp_valid, p1_rsp_valid, sram_we, sram_addr});
    end
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_arbitration();
    test_reset_mid_init();
    test_rsp_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/std_sram_singleport_arb2.md
STD_SRAM_SINGLEPORT_ARB2 -- requirements
Module: std_sram_singleport_arb2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, SRAM data width.
REQ-003 SHALL have parameter INIT_ON_RESET, default 1, 1 = zero-fill the SRAM after reset.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk and reset, both 1-bit inputs; clk is the single clock and reset is the asynchronous, active-high reset.
REQ-005 SHALL have, per port p in {0,1}:
- p_req_valid, input, 1: request present.
- p_req_ready, output, 1: request accepted this cycle.
- p_req_we, input, 1: 1 = write, 0 = read.
- p_req_addr, input, ADDR_WIDTH: request address.
- p_req_wdata, input, DATA_WIDTH: write data.
- p_rsp_valid, output, 1: read data valid.
- p_rsp_rdata, output, DATA_WIDTH: read data.
REQ-006 SHALL have these SRAM-side ports:
- sram_en, output, 1: SRAM access enable.
- sram_we, output, 1: SRAM write enable.
- sram_addr, output, ADDR_WIDTH: SRAM address.
- sram_din, output, DATA_WIDTH: SRAM write data.
- sram_dout, input, DATA_WIDTH: SRAM read data, valid one cycle after a read access.
REQ-007 SHALL have init_done, output, 1: high once the SRAM is usable.

Function
REQ-008 SHALL implement a two-state FSM, INIT and RUN; after reset the state SHALL be INIT if INIT_ON_RESET=1, else RUN.
REQ-009 In INIT, SHALL drive sram_en=1, sram_we=1, sram_din=0 and sram_addr=init counter, which starts at 0 and increments by 1 per cycle.
REQ-010 SHALL go INIT->RUN on the clock edge after the cycle with counter = 2^ADDR_WIDTH-1, so INIT lasts exactly 2^ADDR_WIDTH cycles; the counter SHALL NOT wrap back into further INIT writes.
REQ-011 init_done SHALL be registered: 1 exactly when the state is RUN.
REQ-012 In INIT, both p_req_ready SHALL be 0 and requests SHALL be ignored.
REQ-013 In RUN, with one port valid: that port SHALL be granted that same cycle (ready=1, combinational on valid).
REQ-014 In RUN, with both ports valid: the port not granted most recently SHALL win; the loser's ready SHALL be 0.
REQ-015 The last-grant pointer SHALL update only on a grant and SHALL reset to 1, so port 0 wins the first conflict.
REQ-016 On a grant, SHALL drive sram_en=1 and sram_we, sram_addr, sram_din from the granted port in the same cycle.
REQ-017 In RUN with no grant, sram_en SHALL be 0; sram_we and sram_din SHALL be 0.
REQ-018 Throughput SHALL be one access per cycle with no bubbles between back-to-back grants.
REQ-019 A granted read on port p in cycle T SHALL set p_rsp_valid=1 in cycle T+1 only, via a registered 1-bit valid and a registered port tag.
REQ-020 p_rsp_rdata SHALL equal sram_dout for both ports; the data is meaningful only while p_rsp_valid=1.
REQ-021 Writes SHALL produce no response; there is no response backpressure, and requesters SHALL accept rsp the cycle it is valid.
REQ-022 Requesters SHALL hold valid, we, addr and wdata stable until ready; the block SHALL NOT make ready depend on the same port's we, addr or wdata.
REQ-023 A read to address A granted in the cycle after a write to A SHALL return the new data, because the SRAM is single-port and serialised.

Reset
REQ-024 reset SHALL act asynchronously: state INIT (or RUN if INIT_ON_RESET=0), init counter 0, pointer 1, both rsp_valid 0, init_done 0 (1 if INIT_ON_RESET=0).
REQ-025 During reset, sram_en, sram_we, both p_req_ready and both p_rsp_valid SHALL be 0.
REQ-026 Reset asserted mid-INIT or mid-RUN SHALL abort in-flight responses (no rsp_valid after reset) and SHALL restart INIT from address 0.

Verification
REQ-027 Reset release with INIT_ON_RESET=1, ADDR_WIDTH=4 -> sram_en=we=1 for 16 cycles, addr 0..15, din=0; init_done=1 on cycle 17; then p0 reads addr 5 -> p0_rsp_rdata=0x00.
REQ-028 Port 0 writes 0xA5 to addr 3, then reads addr 3 in the next cycle -> p0_rsp_valid=1 one cycle after the read grant with rdata=0xA5; p1_rsp_valid stays 0.
REQ-029 Both ports hold valid reads (p0 addr 1, p1 addr 2) for 4 cycles -> grants p0,p1,p0,p1, each rsp one cycle later on the matching port.
REQ-030 Port 1 alone streams 4 writes back-to-back -> p1_req_ready=1 for 4 consecutive cycles, sram_en=1 continuously, no rsp_valid.
REQ-031 reset asserted while init counter=7 -> outputs reset immediately; after release INIT restarts at addr 0 and lasts 16 cycles.
REQ-032 reset asserted the cycle after a p0 read grant -> p0_rsp_valid stays 0.
